pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Parametrised program-counter unit for the pipelined core. It replaces the fixed single-branch PC with one that has:
- N prioritised redirect sources;
- a pending-redirect latch that holds a redirect arriving under stall and applies it at release, replacing the delayed-PC and stall-history registers;
- a configurable-depth flush shift chain for the downstream stages.

It sits at the head of IF, driving the fetch address and per-stage flush pulses.

## Interface
Parameters:
- W, 32, PC and target width
- RESET_PC, 32'h0000_0000, PC value after reset
- NSRC, 2, redirect sources; index 0 = oldest stage = highest priority
- FLUSH_DEPTH, 2, number of flush outputs (one per downstream stage)

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset; one clock, synchronous and active-high
- stall  in  1  hold PC (hazard or memory wait); PC unchanged while high
- redir_valid  in  NSRC  per-source redirect request, single-cycle
- redir_target  in  NSRC*W  packed targets; source i at [i*W +: W]
- pc  out  W  current fetch PC (register output)
- pending  out  1  a redirect is latched awaiting stall release
- flush  out  FLUSH_DEPTH  flush[k] pulses k+1 cycles after a redirect commits
- misalign  out  1  target-alignment fault pulse (see Configuration)

## Operation
- Arbitration: the lowest-index asserted redir_valid wins (sel_idx, sel_tgt). Only the winner's target is used.
- Pending latch: holds p_valid, p_idx (clog2(NSRC) bits) and p_tgt (W bits).
- stall=1, new redirect, no pending: latch it; pending=1.
- stall=1, new redirect, pending already held: replace only if sel_idx <= p_idx (older or equal wins; a tie takes the newer).
- stall=1, no new redirect: pending holds. PC holds.
- stall=0, pending and a new redirect: apply the one with the lower index; a tie applies the new one. Clear pending.
- stall=0, only one candidate: apply it; clear pending if it was used.
- stall=0, no candidate: pc <= pc + 4 (modulo 2^W; wrap from all-ones-aligned to 0 is legal and silent).
- Commit: any cycle a redirect is applied to pc. The commit shifts a 1 into the flush chain. Otherwise a 0 shifts in.
- Flush chain advances every cycle regardless of stall. A stalled pipeline consumes the pulse by holding it in its stage-valid logic.

## Timing
- Reset values: pc = RESET_PC, pending = 0, flush = 0, misalign = 0, p_idx = 0, p_tgt = 0.
- Redirect at edge t with stall=0: pc = target from t+1, flush[0]=1 during t+1, flush[k]=1 during t+1+k. Each is a one-cycle pulse.
- Redirect at t with stall=1 released at edge t+n: pending = 1 during t+1 … t+n. pc = target from t+n+1, where the release edge is the first edge with stall=0. Flush follows the same rule as an unstalled commit.
- Back-to-back commits on consecutive cycles give back-to-back flush pulses with no merging loss.
- rst asserted mid-stall or with pending: the latch is discarded, the flush chain is cleared, and pc = RESET_PC on the next edge. rst overrides every other input.
- No combinational path from inputs to pc or flush. pending and misalign are registered.

## Configuration
- PC_ALIGN_CHECK_EN defined: a committed target with [1:0] != 0 is forced to target & ~3. misalign pulses for the one cycle after that commit. The check is made at commit, not at latch time.
- PC_ALIGN_CHECK_EN undefined: targets are used unmodified, and misalign is tied to 0. The port remains so instantiations are identical.

## Structure
- Package pc_pkg holds:
  - INSN_BYTES = 4 and the default RESET_PC;
  - the typedef for the pending-latch record {valid, idx, tgt};
  - a function returning clog2(NSRC) with a minimum of 1.
- Sub-module pc_redirect_arb: a combinational fixed-priority select over NSRC. Outputs any_valid, sel_idx and sel_tgt. It is instantiated once.
- The top level holds the pending latch, the PC register, the flush shift register and the alignment logic.

## Test plan
- Reset then free run, stall=0, no redirects: pc = 0, 4, 8, 12 on consecutive cycles; flush = 0.
- redir_valid = 2'b11 with targets 0x100 (src0) and 0x200 (src1), stall=0: pc = 0x100 next cycle. flush[0] then flush[1] pulse on successive cycles.
- stall=1 for 4 cycles; src1 to 0x200 in stall cycle 1, then src0 to 0x300 in stall cycle 3. pending = 1 throughout the stall. After release pc = 0x300, with one flush sequence only.
- pending src0 to 0x300 with new src1 to 0x400 on the release cycle: pc = 0x300. Repeat with the sources swapped: the src0 target wins.
- rst asserted while pending = 1: pending = 0, pc = RESET_PC, flush = 0 next cycle, and no later flush pulse.
- With PC_ALIGN_CHECK_EN, redirect to 0x102: pc = 0x100 and misalign = 1 for one cycle. Without the macro: pc = 0x102 and misalign = 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg
// Shared constants, types and helpers for the program-counter redirect unit.
//   INSN_BYTES       : fetch step per sequential instruction
//   DEFAULT_RESET_PC : PC value after reset unless overridden
//   pend_t           : pending-redirect record {valid, idx, tgt} for the
//                      default configuration (W = 32, NSRC = 2)
//   idx_width()      : clog2(NSRC) with a floor of 1 bit
package pc_pkg;

   localparam int          INSN_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_W        = 32;
   localparam int          DEFAULT_NSRC     = 2;

   // A single source still needs one index bit so the record never collapses
   // to a zero-width field.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEFAULT_IW = idx_width(DEFAULT_NSRC);

   typedef struct packed {
      logic                  valid;
      logic [DEFAULT_IW-1:0] idx;
      logic [DEFAULT_W-1:0]  tgt;
   } pend_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb
// Combinational fixed-priority select across the redirect sources.
// Source 0 belongs to the oldest pipeline stage and has the highest priority.
// Ports:
//   valid     in  NSRC     per-source redirect request
//   target    in  NSRC*W   packed targets, source i at [i*W +: W]
//   any_valid out 1        at least one request is present
//   sel_idx   out IW       index of the winning source
//   sel_tgt   out W        target of the winning source
module pc_redirect_arb
   import pc_pkg::*;
#(
   parameter int W    = 32,
   parameter int NSRC = 2,
   parameter int IW   = idx_width(NSRC)
) (
   input  logic [NSRC-1:0]   valid,
   input  logic [NSRC*W-1:0] target,
   output logic              any_valid,
   output logic [IW-1:0]     sel_idx,
   output logic [W-1:0]      sel_tgt
);

   // Walking from the highest index down lets each lower-index request
   // overwrite the previous choice, so the lowest asserted index wins.
   always_comb begin
      any_valid = 1'b0;
      sel_idx   = '0;
      sel_tgt   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (valid[i]) begin
            any_valid = 1'b1;
            sel_idx   = IW'(i);
            sel_tgt   = target[i*W +: W];
         end
      end
   end

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
// Fetch-address generator at the head of IF. Handles NSRC prioritised
// redirects, holds a redirect that arrives under stall until release, and
// drives a flush pulse chain for the downstream stages.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : committed targets are forced to 4-byte alignment and
//               misalign pulses for one cycle after such a commit
//   undefined : targets are used as-is, misalign is constant 0
// Ports:
//   clk, rst      core clock; synchronous active-high reset
//   stall         hold the PC
//   redir_valid   per-source redirect requests
//   redir_target  packed per-source targets
//   pc            registered fetch PC
//   pending       a redirect is latched waiting for stall release
//   flush         flush[k] pulses k+1 cycles after a commit
//   misalign      alignment-fault pulse
module pc_redirect_unit
   import pc_pkg::*;
#(
   parameter int             W           = 32,
   parameter logic [W-1:0]   RESET_PC    = W'(DEFAULT_RESET_PC),
   parameter int             NSRC        = 2,
   parameter int             FLUSH_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic [NSRC-1:0]        redir_valid,
   input  logic [NSRC*W-1:0]      redir_target,
   output logic [W-1:0]           pc,
   output logic                   pending,
   output logic [FLUSH_DEPTH-1:0] flush,
   output logic                   misalign
);

   localparam int IW = idx_width(NSRC);

   typedef struct packed {
      logic          valid;
      logic [IW-1:0] idx;
      logic [W-1:0]  tgt;
   } latch_t;

   logic                   any_valid;
   logic [IW-1:0]          sel_idx;
   logic [W-1:0]           sel_tgt;
   latch_t                 pend_q;
   latch_t                 pend_d;
   logic                   commit;
   logic [W-1:0]           commit_raw;
   logic [W-1:0]           commit_tgt;
   logic [W-1:0]           pc_q;
   logic [FLUSH_DEPTH-1:0] flush_q;

   pc_redirect_arb #(
      .W    (W),
      .NSRC (NSRC),
      .IW   (IW)
   ) u_arb (
      .valid     (redir_valid),
      .target    (redir_target),
      .any_valid (any_valid),
      .sel_idx   (sel_idx),
      .sel_tgt   (sel_tgt)
   );

   // Decide whether this cycle commits a redirect and what the pending latch
   // becomes. Under stall a new redirect only displaces a held one when it
   // comes from the same or an older stage. On release the held and the new
   // redirect compete by index (tie goes to the new one) and the latch empties
   // either way, because a younger redirect is made moot by an older one.
   always_comb begin
      commit     = 1'b0;
      commit_raw = '0;
      pend_d     = pend_q;
      if (stall) begin
         if (any_valid && (!pend_q.valid || sel_idx <= pend_q.idx)) begin
            pend_d.valid = 1'b1;
            pend_d.idx   = sel_idx;
            pend_d.tgt   = sel_tgt;
         end
      end else begin
         pend_d = '0;
         if (pend_q.valid && any_valid) begin
            commit     = 1'b1;
            commit_raw = (sel_idx <= pend_q.idx) ? sel_tgt : pend_q.tgt;
         end else if (pend_q.valid) begin
            commit     = 1'b1;
            commit_raw = pend_q.tgt;
         end else if (any_valid) begin
            commit     = 1'b1;
            commit_raw = sel_tgt;
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   // Alignment is judged on the target actually committed, not the one that
   // was latched, so a superseded misaligned target never raises a fault.
   always_comb begin
      commit_tgt = {commit_raw[W-1:2], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= commit && (commit_raw[1:0] != 2'b00);
      end
   end

   assign misalign = misalign_q;
`else
   always_comb begin
      commit_tgt = commit_raw;
   end

   assign misalign = 1'b0;
`endif

   // PC register, pending latch and flush chain. The flush chain shifts every
   // cycle, even under stall; downstream stages hold the pulse themselves.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         flush_q <= '0;
      end else begin
         pend_q  <= pend_d;
         flush_q <= FLUSH_DEPTH'({flush_q, commit});
         if (commit) begin
            pc_q <= commit_tgt;
         end else if (!stall) begin
            pc_q <= pc_q + W'(INSN_BYTES);
         end
      end
   end

   assign pc      = pc_q;
   assign pending = pend_q.valid;
   assign flush   = flush_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit
// Self-checking bench for pc_redirect_unit in its default configuration
// (W=32, NSRC=2, FLUSH_DEPTH=2). Directed scenarios followed by randomized
// traffic, all checked against a cycle-level reference model that reasons in
// terms of "which redirect is outstanding" and "when did commits happen".
module tb_pc_redirect_unit;
   import pc_pkg::*;

   localparam int          W    = 32;
   localparam int          NSRC = 2;
   localparam int          FD   = 2;
   localparam logic [31:0] RPC  = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic [NSRC-1:0]   redir_valid;
   logic [NSRC*W-1:0] redir_target;
   logic [W-1:0]      pc;
   logic              pending;
   logic [FD-1:0]     flush;
   logic              misalign;

   pc_redirect_unit #(
      .W           (W),
      .RESET_PC    (RPC),
      .NSRC        (NSRC),
      .FLUSH_DEPTH (FD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .pc           (pc),
      .pending      (pending),
      .flush        (flush),
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [31:0] m_pc;
   pend_t       m_pend;
   bit          m_mis;
   bit          hist[$];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One clock of the reference model.
   task automatic modelStep(input bit r, input bit s, input logic [1:0] v,
                            input logic [31:0] t0, input logic [31:0] t1);
      bit          have_new;
      int          new_idx;
      logic [31:0] new_tgt;
      bit          commit;
      logic [31:0] ctgt;
      if (r) begin
         m_pc   = RPC;
         m_pend = '0;
         m_mis  = 1'b0;
         hist.delete();
         return;
      end
      have_new = 1'b0;
      new_idx  = 0;
      new_tgt  = '0;
      if (v[0]) begin
         have_new = 1'b1; new_idx = 0; new_tgt = t0;
      end else if (v[1]) begin
         have_new = 1'b1; new_idx = 1; new_tgt = t1;
      end
      commit = 1'b0;
      ctgt   = '0;
      if (s) begin
         if (have_new && (!m_pend.valid || new_idx <= int'(m_pend.idx))) begin
            m_pend.valid = 1'b1;
            m_pend.idx   = DEFAULT_IW'(new_idx);
            m_pend.tgt   = new_tgt;
         end
      end else begin
         if (m_pend.valid && have_new) begin
            commit = 1'b1;
            ctgt   = (new_idx <= int'(m_pend.idx)) ? new_tgt : m_pend.tgt;
         end else if (m_pend.valid) begin
            commit = 1'b1;
            ctgt   = m_pend.tgt;
         end else if (have_new) begin
            commit = 1'b1;
            ctgt   = new_tgt;
         end
         m_pend.valid = 1'b0;
      end
`ifdef PC_ALIGN_CHECK_EN
      m_mis = commit && (ctgt % 4 != 0);
      ctgt  = ctgt - (ctgt % 4);
`else
      m_mis = 1'b0;
`endif
      if (commit) m_pc = ctgt;
      else if (!s) m_pc = m_pc + 32'd4;
      hist.push_back(commit);
      if (hist.size() > FD) void'(hist.pop_front());
   endtask

   // Drive one cycle of inputs, advance model and DUT, then compare everything.
   task automatic applyStimulus(input bit r, input bit s, input logic [1:0] v,
                                input logic [31:0] t0, input logic [31:0] t1);
      logic [FD-1:0] exp_flush;
      rst          = r;
      stall        = s;
      redir_valid  = v;
      redir_target = {t1, t0};
      @(posedge clk);
      modelStep(r, s, v, t0, t1);
      #1;
      exp_flush = '0;
      for (int k = 0; k < FD; k++) begin
         if (hist.size() - 1 - k >= 0) exp_flush[k] = hist[hist.size() - 1 - k];
      end
      checkOutput("pc", 64'(pc), 64'(m_pc));
      checkOutput("pending", 64'(pending), 64'(m_pend.valid));
      checkOutput("flush", 64'(flush), 64'(exp_flush));
      checkOutput("misalign", 64'(misalign), 64'(m_mis));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
   endtask

   initial begin
      logic [31:0] rt0, rt1;
      logic [1:0]  rv;
      bit          rs, rr;
      rst          = 1'b1;
      stall        = 1'b0;
      redir_valid  = '0;
      redir_target = '0;
      m_pend       = '0;

      $display("[TB] reset and free run");
      applyStimulus(1'b1, 1'b0, 2'b00, '0, '0);
      checkOutput("reset_pc", 64'(pc), 64'(RPC));
      checkOutput("reset_flush", 64'(flush), 64'd0);
      idle(3);
      checkOutput("free_run_pc", 64'(pc), 64'h0C);

      $display("[TB] dual redirect, src0 wins");
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h100, 32'h200);
      checkOutput("redir_pc", 64'(pc), 64'h100);
      checkOutput("redir_flush0", 64'(flush), 64'b01);
      idle(1);
      checkOutput("redir_flush1", 64'(flush), 64'b10);
      idle(1);
      checkOutput("redir_flush_done", 64'(flush), 64'b00);

      $display("[TB] redirects under stall");
      applyStimulus(1'b0, 1'b1, 2'b10, 32'h0, 32'h200);
      applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 2'b01, 32'h300, 32'h0);
      applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      checkOutput("stall_pending", 64'(pending), 64'd1);
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      checkOutput("release_pc", 64'(pc), 64'h300);
      idle(3);

      $display("[TB] pending vs new redirect at release");
      applyStimulus(1'b0, 1'b1, 2'b01, 32'h300, 32'h0);
      applyStimulus(1'b0, 1'b0, 2'b10, 32'h0, 32'h400);
      checkOutput("pend_src0_wins", 64'(pc), 64'h300);
      applyStimulus(1'b0, 1'b1, 2'b10, 32'h0, 32'h400);
      applyStimulus(1'b0, 1'b0, 2'b01, 32'h300, 32'h0);
      checkOutput("new_src0_wins", 64'(pc), 64'h300);
      idle(2);

      $display("[TB] reset while pending");
      applyStimulus(1'b0, 1'b1, 2'b01, 32'h500, 32'h0);
      applyStimulus(1'b1, 1'b1, 2'b01, 32'h600, 32'h0);
      checkOutput("rst_pending", 64'(pending), 64'd0);
      checkOutput("rst_pc", 64'(pc), 64'(RPC));
      idle(3);
      checkOutput("rst_no_flush", 64'(flush), 64'd0);

      $display("[TB] misaligned target and wrap");
      applyStimulus(1'b0, 1'b0, 2'b01, 32'h102, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      checkOutput("align_pc", 64'(pc), 64'h100);
      checkOutput("align_fault", 64'(misalign), 64'd1);
`else
      checkOutput("align_pc", 64'(pc), 64'h102);
      checkOutput("align_fault", 64'(misalign), 64'd0);
`endif
      idle(1);
      applyStimulus(1'b0, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
      idle(1);
      checkOutput("wrap_pc", 64'(pc), 64'h0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 2000; n++) begin
         rr  = ($urandom_range(0, 49) == 0);
         rs  = ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
         rt0 = $urandom;
         rt1 = $urandom;
         if ($urandom_range(0, 3) != 0) rt0[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) rt1[1:0] = 2'b00;
         applyStimulus(rr, rs, rv, rt0, rt1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
